// File: rtl/codec_i2s_link.sv
// codec_i2s_link: I2S master towards a slave-mode codec, all clocks derived from clk18 (= MCLK).
// Sends sample_in on both DAC channels; with CODEC_ADC_EN defined, captures the left ADC word into linein.
module codec_i2s_link #(
  parameter int BCK_DIV = 6
) (
  input  logic        clk18,
  input  logic        reset_n,
  input  logic [15:0] sample_in,
  output logic        sample_strobe,
  output logic [15:0] linein,
  output logic        linein_valid,
  output logic        oAUD_BCK,
  output logic        oAUD_LRCK,
  output logic        oAUD_DATA,
  input  logic        iAUD_ADCDAT,
  output logic        oAUD_ADCLRCK
);

  localparam int PW   = $clog2(BCK_DIV);
  localparam int HALF = BCK_DIV / 2;

  logic [PW-1:0] p_q, p_d;
  logic [5:0]    s_q, s_d;
  logic          bck_q, bck_d;
  logic          strobe_q, strobe_d;
  logic [15:0]   hold_q, hold_d;
  logic          data_q, data_d;
  logic          bck_fall;
  logic [4:0]    b_next;
  logic [3:0]    bit_idx;

  always_comb begin
    bck_fall = (p_q == PW'(BCK_DIV - 1));
    p_d      = bck_fall ? '0 : p_q + PW'(1);
    s_d      = bck_fall ? s_q + 6'd1 : s_q;
    bck_d    = (p_d >= PW'(HALF));
    strobe_d = bck_fall && (s_q == 6'd63);
    // hold is written at the end of the strobe cycle, well before the first data bit leaves
    hold_d   = strobe_q ? sample_in : hold_q;
    b_next   = s_d[4:0];
    bit_idx  = 4'd15 - 4'(b_next - 5'd1);
    data_d   = data_q;
    if (bck_fall) begin
      data_d = (b_next >= 5'd1 && b_next <= 5'd16) ? hold_q[bit_idx] : 1'b0;
    end
  end

  always_ff @(posedge clk18 or negedge reset_n) begin
    if (!reset_n) begin
      p_q      <= '0;
      s_q      <= '0;
      bck_q    <= 1'b0;
      strobe_q <= 1'b0;
      hold_q   <= '0;
      data_q   <= 1'b0;
    end else begin
      p_q      <= p_d;
      s_q      <= s_d;
      bck_q    <= bck_d;
      strobe_q <= strobe_d;
      hold_q   <= hold_d;
      data_q   <= data_d;
    end
  end

  assign sample_strobe = strobe_q;
  assign oAUD_BCK      = bck_q;
  assign oAUD_LRCK     = s_q[5];
  assign oAUD_ADCLRCK  = s_q[5];
  assign oAUD_DATA     = data_q;

`ifdef CODEC_ADC_EN
  logic [15:0] sr_q, sr_d;
  logic [15:0] linein_q, linein_d;
  logic        valid_q, valid_d;
  logic        bck_rise;
  logic [4:0]  b_cur;

  always_comb begin
    bck_rise = (p_q == PW'(HALF - 1));
    b_cur    = s_q[4:0];
    sr_d     = sr_q;
    linein_d = linein_q;
    valid_d  = 1'b0;
    // the codec launches on BCK falling edges, so the bit is taken at the rising edge
    if (bck_rise && !s_q[5] && b_cur >= 5'd1 && b_cur <= 5'd16) begin
      sr_d = {sr_q[14:0], iAUD_ADCDAT};
      if (b_cur == 5'd16) begin
        linein_d = sr_d;
        valid_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk18 or negedge reset_n) begin
    if (!reset_n) begin
      sr_q     <= '0;
      linein_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      sr_q     <= sr_d;
      linein_q <= linein_d;
      valid_q  <= valid_d;
    end
  end

  assign linein       = linein_q;
  assign linein_valid = valid_q;
`else
  logic adc_unused;
  assign adc_unused   = iAUD_ADCDAT;
  assign linein       = '0;
  assign linein_valid = 1'b0;
`endif

endmodule

// File: tb/tb_codec_i2s_link.sv
// Bench for codec_i2s_link: cycle-index reference model of the I2S framing plus a codec ADC driver.
`timescale 1ns/1ps
module tb_codec_i2s_link;
  localparam int D     = 6;
  localparam int HALF  = D / 2;
  localparam int FRAME = 64 * D;
`ifdef CODEC_ADC_EN
  localparam logic [15:0] EXP_LI   = 16'h8001;
  localparam int          EXP_VCNT = 1;
`else
  localparam logic [15:0] EXP_LI   = 16'h0000;
  localparam int          EXP_VCNT = 0;
`endif

  logic        clk18 = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] sample_in = 16'h0000;
  logic        iAUD_ADCDAT = 1'b0;
  logic        sample_strobe, linein_valid, oAUD_BCK, oAUD_LRCK, oAUD_DATA, oAUD_ADCLRCK;
  logic [15:0] linein;

  int          checks = 0;
  int          failures = 0;
  int          k = 0;
  bit          chk_en = 1'b0;
  bit          random_adc = 1'b0;
  logic [15:0] adc_left = 16'h8001;
  logic [15:0] adc_right = 16'h7FFF;
  logic [15:0] model_hold = 16'h0000;
  logic [15:0] exp_linein = 16'h0000;

  codec_i2s_link #(.BCK_DIV(D)) dut (
    .clk18        (clk18),
    .reset_n      (reset_n),
    .sample_in    (sample_in),
    .sample_strobe(sample_strobe),
    .linein       (linein),
    .linein_valid (linein_valid),
    .oAUD_BCK     (oAUD_BCK),
    .oAUD_LRCK    (oAUD_LRCK),
    .oAUD_DATA    (oAUD_DATA),
    .iAUD_ADCDAT  (iAUD_ADCDAT),
    .oAUD_ADCLRCK (oAUD_ADCLRCK)
  );

  initial forever #5 clk18 = ~clk18;

  // k = clk18 cycles since reset release; every expectation is a function of k
  always @(posedge clk18 or negedge reset_n) begin
    if (!reset_n) k <= 0;
    else          k <= k + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at k=%0d: got %h expected %h", name, k, act, exp);
    end
  endtask

  task automatic wait_k(input int target);
    int n = 0;
    while (k != target && n < 3 * FRAME) begin
      @(negedge clk18);
      n++;
    end
    if (k != target) begin
      checks++;
      failures++;
      $display("FAIL wait_k timeout: k=%0d expected %0d", k, target);
    end
  endtask

  task automatic capture(input int base, output logic [15:0] l, output logic [15:0] r);
    l = '0;
    r = '0;
    for (int b = 1; b <= 16; b++) begin
      wait_k(base + b * D + HALF);
      l = {l[14:0], oAUD_DATA};
    end
    for (int b = 33; b <= 48; b++) begin
      wait_k(base + b * D + HALF);
      r = {r[14:0], oAUD_DATA};
    end
  endtask

  // codec model: launches bits right after each clk18 edge, slot-aligned to the link frame
  initial forever begin
    @(posedge clk18);
    #1;
    begin : drv
      int p, sl, b;
      p  = k % D;
      sl = (k / D) % 64;
      b  = sl % 32;
      if (p == 0 && sl == 0 && random_adc) begin
        adc_left  = 16'($urandom);
        adc_right = 16'($urandom);
      end
      if (b >= 1 && b <= 16) iAUD_ADCDAT = (sl < 32) ? adc_left[16 - b] : adc_right[16 - b];
      else                   iAUD_ADCDAT = 1'($urandom);
    end
  end

  always @(negedge clk18) begin : cmp
    int   p, sl, b;
    logic ed, ev, es;
    if (!reset_n) begin
      model_hold = '0;
      exp_linein = '0;
    end else if (chk_en) begin
      p  = k % D;
      sl = (k / D) % 64;
      b  = sl % 32;
      ed = (b >= 1 && b <= 16) ? model_hold[16 - b] : 1'b0;
      es = (k > 0) && (k % FRAME == 0);
`ifdef CODEC_ADC_EN
      ev = (sl == 16) && (p == HALF);
      if (ev) exp_linein = adc_left;
`else
      ev = 1'b0;
`endif
      check("bck", oAUD_BCK, p >= HALF);
      check("lrck", oAUD_LRCK, sl >= 32);
      check("adclrck", oAUD_ADCLRCK, sl >= 32);
      check("data", oAUD_DATA, ed);
      check("strobe", sample_strobe, es);
      check("linein_valid", linein_valid, ev);
      check("linein", linein, exp_linein);
      if (es) model_hold = sample_in;
    end
  end

  initial begin
    int          first_strobe, lr_hi, bck_hi, vcnt, base;
    logic [15:0] cl, cr;

    repeat (3) @(posedge clk18);
    #2;
    check("rst_bck", oAUD_BCK, 0);
    check("rst_lrck", oAUD_LRCK, 0);
    check("rst_data", oAUD_DATA, 0);
    check("rst_strobe", sample_strobe, 0);
    check("rst_linein", linein, 0);
    check("rst_valid", linein_valid, 0);
    @(negedge clk18);
    #1;
    reset_n = 1'b1;
    chk_en  = 1'b1;

    first_strobe = -1;
    lr_hi  = 0;
    bck_hi = 0;
    for (int i = 0; i < FRAME + 4; i++) begin
      @(negedge clk18);
      if (k < FRAME && oAUD_LRCK) lr_hi++;
      if (k < FRAME && oAUD_BCK) bck_hi++;
      if (sample_strobe && first_strobe < 0) first_strobe = k;
    end
    check("first_strobe_k", first_strobe, 384);
    check("lrck_high_first_frame", lr_hi, 192);
    check("bck_high_first_frame", bck_hi, 192);

    @(posedge clk18);
    #1;
    sample_in = 16'hA5C3;
    capture(2 * FRAME, cl, cr);
    check("a5c3_left", cl, 16'hA5C3);
    check("a5c3_right", cr, 16'hA5C3);

    wait_k(3 * FRAME);
    @(posedge clk18);
    #1;
    sample_in = 16'h0001;
    capture(3 * FRAME, cl, cr);
    check("late_change_left", cl, 16'hA5C3);
    check("late_change_right", cr, 16'hA5C3);
    capture(4 * FRAME, cl, cr);
    check("lsb_left", cl, 16'h0001);
    check("lsb_right", cr, 16'h0001);

    wait_k(5 * FRAME);
    vcnt = 0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk18);
      if (linein_valid) vcnt++;
    end
    check("valid_per_frame", vcnt, EXP_VCNT);
    check("linein_left_word", linein, EXP_LI);

    random_adc = 1'b1;
    for (int i = 0; i < 5 * FRAME; i++) begin
      @(posedge clk18);
      #1;
      if (k % FRAME == 0 && $urandom_range(0, 1) == 1) sample_in = 16'($urandom);
      else if ($urandom_range(0, 39) == 0)             sample_in = 16'($urandom);
    end

    base = (k / FRAME + 1) * FRAME;
    wait_k(base + 40 * D + 2);
    #1;
    reset_n = 1'b0;
    #1;
    check("arst_bck", oAUD_BCK, 0);
    check("arst_lrck", oAUD_LRCK, 0);
    check("arst_data", oAUD_DATA, 0);
    check("arst_linein", linein, 0);
    check("arst_strobe", sample_strobe, 0);
    repeat (2) @(posedge clk18);
    @(negedge clk18);
    #1;
    reset_n = 1'b1;
    wait_k(16 * D + HALF - 1);
    check("post_rst_linein_zero", linein, 0);
    wait_k(16 * D + HALF);
    check("post_rst_first_valid", linein_valid, EXP_VCNT);
    wait_k(383);
    check("post_rst_no_early_strobe", sample_strobe, 0);
    wait_k(384);
    check("post_rst_strobe", sample_strobe, 1);

    for (int i = 0; i < 2 * FRAME; i++) begin
      @(posedge clk18);
      #1;
      if ($urandom_range(0, 29) == 0) sample_in = 16'($urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
